line_clear_ctrl: RTL and testbench

//  Multi-cycle sequencer that removes completed rows from the stacked-block board after a piece locks.
//  It latches a snapshot of the board on start and scans one row per cycle, bottom to top.
//  Non-full rows are compacted downward in place, and the rows freed at the top are zero-filled.
//  It returns the new board and the number of rows cleared; the main game FSM and score logic consume both.

---
 rtl/line_clear_ctrl_pkg.sv | 12 +
 rtl/line_clear_ctrl.sv | 107 ++++++++++
 tb/tb_line_clear_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_clear_ctrl_pkg.sv
// Shared board geometry and line-clear sequencer state encodings.
package line_clear_ctrl_pkg;

  localparam int BOARD_WIDTH_BLK  = 10;
  localparam int BOARD_HEIGHT_BLK = 20;

  localparam logic [1:0] LC_IDLE = 2'd0;
  localparam logic [1:0] LC_SCAN = 2'd1;
  localparam logic [1:0] LC_FILL = 2'd2;
  localparam logic [1:0] LC_DONE = 2'd3;

endpackage

// File: rtl/line_clear_ctrl.sv
// Line-clear sequencer: snapshots the board, scans rows bottom to top while
// compacting non-full rows downward in place, zero-fills the freed top rows,
// then presents the new board and the number of rows removed.
module line_clear_ctrl
  import line_clear_ctrl_pkg::*;
#(
  parameter int W  = BOARD_WIDTH_BLK,
  parameter int H  = BOARD_HEIGHT_BLK,
  parameter int CW = $clog2(H + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [W*H-1:0]    board_in,
  output logic              busy,
  output logic              done,
  output logic [W*H-1:0]    board_out,
  output logic [CW-1:0]     lines_cleared
);

  localparam int RW = (H > 1) ? $clog2(H) : 1;

  logic [1:0]      state;
  logic [W*H-1:0]  work;
  logic [W*H-1:0]  work_nxt;
  logic [RW-1:0]   src;
  logic [RW-1:0]   dst;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic [W-1:0]    src_row;
  logic            src_full;

  assign busy = (state != LC_IDLE);
  assign done = (state == LC_DONE);

  // Row being examined this cycle and the board as it will look after this cycle's row write.
  always_comb begin
    src_row  = work[int'(src)*W +: W];
    src_full = &src_row;
    cnt_nxt  = cnt + {{(CW-1){1'b0}}, src_full};
    work_nxt = work;
    if (state == LC_SCAN) begin
      if (!src_full) begin
        work_nxt[int'(dst)*W +: W] = src_row;
      end
    end else if (state == LC_FILL) begin
      work_nxt[int'(dst)*W +: W] = '0;
    end
  end

  // Sequencer: latch snapshot, compact rows, clear freed top rows, publish result on entering DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= LC_IDLE;
      work          <= '0;
      src           <= '0;
      dst           <= '0;
      cnt           <= '0;
      board_out     <= '0;
      lines_cleared <= '0;
    end else begin
      case (state)
        LC_IDLE: begin
          if (start) begin
            work  <= board_in;
            src   <= RW'(H - 1);
            dst   <= RW'(H - 1);
            cnt   <= '0;
            state <= LC_SCAN;
          end
        end
        LC_SCAN: begin
          work <= work_nxt;
          cnt  <= cnt_nxt;
          if (!src_full && (dst != '0)) begin
            dst <= dst - 1'b1;
          end
          if (src == '0) begin
            if (cnt_nxt != '0) begin
              state <= LC_FILL;
            end else begin
              state         <= LC_DONE;
              board_out     <= work_nxt;
              lines_cleared <= cnt_nxt;
            end
          end else begin
            src <= src - 1'b1;
          end
        end
        LC_FILL: begin
          work <= work_nxt;
          if (dst == '0) begin
            state         <= LC_DONE;
            board_out     <= work_nxt;
            lines_cleared <= cnt;
          end else begin
            dst <= dst - 1'b1;
          end
        end
        default: begin
          state <= LC_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Self-checking bench for line_clear_ctrl: directed boards, randomized boards
// against a queue-based compaction model, ignored start requests and mid-pass reset.
module tb_line_clear_ctrl;

  localparam int W  = 10;
  localparam int H  = 20;
  localparam int CW = 5;
  localparam int N  = W * H;

  logic           clk;
  logic           rst;
  logic           start;
  logic [N-1:0]   board_in;
  logic           busy;
  logic           done;
  logic [N-1:0]   board_out;
  logic [CW-1:0]  lines_cleared;

  int n_checks = 0;
  int n_fail   = 0;

  line_clear_ctrl #(.W(W), .H(H), .CW(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .board_in     (board_in),
    .busy         (busy),
    .done         (done),
    .board_out    (board_out),
    .lines_cleared(lines_cleared)
  );

  // 100 MHz-style free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: drop full rows, stack the survivors at the bottom in original order, zeros above.
  function automatic void model(input logic [N-1:0] b, output logic [N-1:0] o, output logic [CW-1:0] c);
    logic [W-1:0] kept[$];
    logic [W-1:0] row;
    int full;
    full = 0;
    o = '0;
    for (int r = H - 1; r >= 0; r--) begin
      row = b[r*W +: W];
      if (row == {W{1'b1}}) full++;
      else kept.push_back(row);
    end
    for (int i = 0; i < kept.size(); i++) o[(H-1-i)*W +: W] = kept[i];
    c = CW'(full);
  endfunction

  function automatic logic [N-1:0] rand_board(input int full_pct);
    logic [N-1:0] b;
    b = '0;
    for (int r = 0; r < H; r++) begin
      if (int'($urandom_range(0, 99)) < full_pct) b[r*W +: W] = {W{1'b1}};
      else if ($urandom_range(0, 3) == 0) b[r*W +: W] = '0;
      else b[r*W +: W] = W'($urandom);
    end
    return b;
  endfunction

  // Drives one pass and reports what the DUT produced; optionally fires stray start requests.
  task automatic run_pass(input logic [N-1:0] b, input bit inject,
                          output logic [N-1:0] ob, output logic [CW-1:0] ol,
                          output int lat, output bit held_ok, output bit busy_ok, output bit after_ok);
    logic [N-1:0]  prev_b;
    logic [CW-1:0] prev_l;
    prev_b   = board_out;
    prev_l   = lines_cleared;
    held_ok  = 1'b1;
    busy_ok  = 1'b1;
    after_ok = 1'b1;
    lat      = -1;
    ob       = 'x;
    ol       = 'x;
    board_in = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    board_in = rand_board(50);
    for (int k = 1; k <= 2*H + 10; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (board_out !== prev_b || lines_cleared !== prev_l) held_ok = 1'b0;
      start    = (inject && k == 4) ? 1'b1 : 1'b0;
      board_in = rand_board(50);
    end
    if (lat > 0) begin
      ob = board_out;
      ol = lines_cleared;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (inject) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done !== 1'b0 || busy !== 1'b0) after_ok = 1'b0;
      @(posedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0) after_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    start    = 1'b0;
    board_in = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || board_out !== '0 || lines_cleared !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_state: busy=%b done=%b lines=%0d board_nonzero=%b, required all zero",
               busy, done, lines_cleared, |board_out);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    logic [N-1:0]  b [5];
    logic [N-1:0]  eb[5];
    logic [CW-1:0] el[5];
    int            elat[5];
    logic [N-1:0]  ob;
    logic [CW-1:0] ol;
    int            lat;
    bit            held_ok, busy_ok, after_ok;
    for (int i = 0; i < 5; i++) begin b[i] = '0; eb[i] = '0; end
    b[1][190 +: W] = '1; b[1][180] = 1'b1;
    for (int r = 16; r <= 19; r++) b[2][r*W +: W] = '1;
    b[2][150] = 1'b1;
    b[3][170 +: W] = '1; b[3][190 +: W] = '1; b[3][185] = 1'b1;
    b[4] = '1;
    eb[1][190] = 1'b1; eb[2][190] = 1'b1; eb[3][195] = 1'b1;
    el[0] = 0;  el[1] = 1;  el[2] = 4;  el[3] = 2;  el[4] = 20;
    elat[0] = 20; elat[1] = 21; elat[2] = 24; elat[3] = 22; elat[4] = 40;
    for (int i = 0; i < 5; i++) begin
      run_pass(b[i], 1'b0, ob, ol, lat, held_ok, busy_ok, after_ok);
      n_checks++;
      if (lat != elat[i]) begin
        n_fail++;
        $display("[TB] FAIL directed%0d_latency: got %0d edges, required %0d", i + 1, lat, elat[i]);
      end
      n_checks++;
      if (ol !== el[i]) begin
        n_fail++;
        $display("[TB] FAIL directed%0d_lines: got %0d, required %0d", i + 1, ol, el[i]);
      end
      n_checks++;
      if (ob !== eb[i]) begin
        n_fail++;
        $display("[TB] FAIL directed%0d_board: got %h, required %h", i + 1, ob, eb[i]);
      end
      n_checks++;
      if (!held_ok || !busy_ok || !after_ok) begin
        n_fail++;
        $display("[TB] FAIL directed%0d_handshake: held=%0d busy=%0d after=%0d, required 1 1 1",
                 i + 1, held_ok, busy_ok, after_ok);
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0]  b, ob, eb;
    logic [CW-1:0] ol, el;
    int            lat;
    bit            held_ok, busy_ok, after_ok;
    for (int i = 0; i < 40; i++) begin
      b = rand_board((i % 4) * 25);
      model(b, eb, el);
      run_pass(b, 1'b0, ob, ol, lat, held_ok, busy_ok, after_ok);
      n_checks++;
      if (lat != H + int'(el) || ol !== el || ob !== eb) begin
        n_fail++;
        $display("[TB] FAIL random%0d: lat=%0d lines=%0d board=%h, required lat=%0d lines=%0d board=%h",
                 i, lat, ol, ob, H + int'(el), el, eb);
      end
      n_checks++;
      if (!held_ok || !busy_ok || !after_ok) begin
        n_fail++;
        $display("[TB] FAIL random%0d_handshake: held=%0d busy=%0d after=%0d, required 1 1 1",
                 i, held_ok, busy_ok, after_ok);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [N-1:0]  b, ob, eb;
    logic [CW-1:0] ol, el;
    int            lat;
    bit            held_ok, busy_ok, after_ok;
    b = '0;
    for (int r = 12; r < H; r += 2) b[r*W +: W] = '1;
    b[115] = 1'b1; b[63] = 1'b1;
    model(b, eb, el);
    run_pass(b, 1'b1, ob, ol, lat, held_ok, busy_ok, after_ok);
    n_checks++;
    if (lat != H + int'(el) || ol !== el || ob !== eb) begin
      n_fail++;
      $display("[TB] FAIL ignore_start_result: lat=%0d lines=%0d board=%h, required lat=%0d lines=%0d board=%h",
               lat, ol, ob, H + int'(el), el, eb);
    end
    n_checks++;
    if (!after_ok || !busy_ok) begin
      n_fail++;
      $display("[TB] FAIL ignore_start_requeue: after=%0d busy=%0d, required 1 1", after_ok, busy_ok);
    end
  endtask

  task automatic test_reset_mid_pass();
    logic [N-1:0] b;
    bit saw_done;
    b = '1;
    saw_done = 1'b0;
    n_checks++;
    if (board_out === '0) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_precondition: board_out is 0, required nonzero from prior pass");
    end
    board_in = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || board_out !== '0 || lines_cleared !== '0) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_outputs: busy=%b done=%b lines=%0d board_nonzero=%b, required all zero",
               busy, done, lines_cleared, |board_out);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_no_done: saw done/busy activity=1, required 0");
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    board_in = '0;
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_mid_pass();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
